sc_shift_pingpong_ctrl: RTL and testbench

SC_SHIFT_PINGPONG_CTRL -- requirements
Module: sc_shift_pingpong_ctrl

---
 rtl/sc_shiftctrl_pkg.sv | 19 +
 rtl/sc_shiftctrl_prescaler.sv | 39 +++
 rtl/sc_shift_pingpong_ctrl.sv | 159 +++++++++++++++
 tb/tb_sc_shift_pingpong_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_shiftctrl_pkg.sv
// Shared types and constants for the ping-pong shift controller.
// Optional bounce counter is enabled by SC_SHIFTCTRL_BOUNCECOUNT_EN in the top.
package sc_shiftctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_LEFT  = 2'd1,
    RUN_RIGHT = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Counter width that still works for a divide-by-one prescaler.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_shiftctrl_prescaler.sv
// Step prescaler: down-counter that pulses step_o once every STEP_CYCLES enabled cycles.
// clear_i reloads so the first step lands exactly STEP_CYCLES cycles later.
module sc_shiftctrl_prescaler
  import sc_shiftctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic step_o
);

  localparam int unsigned CW = cnt_width(STEP_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = RELOAD;
    end else if (enable_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/sc_shift_pingpong_ctrl.sv
// Ping-pong shift controller: bounces a pattern between the register ends via an external shifter.
// Define SC_SHIFTCTRL_BOUNCECOUNT_EN to add the 8-bit bounce counter output.
//
// state     | meaning
// IDLE      | stopped, data and dir held, waiting for a start press
// RUN_LEFT  | stepping data toward the MSB (dir = 0)
// RUN_RIGHT | stepping data toward the LSB (dir = 1)
module sc_shift_pingpong_ctrl
  import sc_shiftctrl_pkg::*;
#(
  parameter int unsigned RegSHIFTER_DATAWIDTH = 4,
  parameter int unsigned STEP_CYCLES          = 4
) (
  input  logic                            SC_ShiftCtrl_CLOCK_50,
  input  logic                            SC_ShiftCtrl_RESET_InLow,
  input  logic                            SC_ShiftCtrl_startButton_InLow,
  input  logic [RegSHIFTER_DATAWIDTH-1:0] SC_ShiftCtrl_load_InBUS,
  input  logic [RegSHIFTER_DATAWIDTH-1:0] SC_ShiftCtrl_shifted_InBUS,
  output logic [RegSHIFTER_DATAWIDTH-1:0] SC_ShiftCtrl_data_OutBUS,
  output logic                            SC_ShiftCtrl_dir_Out,
  output logic                            SC_ShiftCtrl_busy_Out,
  output logic                            SC_ShiftCtrl_bounce_Out
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
  ,
  output logic [7:0]                      SC_ShiftCtrl_bounces_OutBUS
`endif
);

  localparam int unsigned W = RegSHIFTER_DATAWIDTH;

  logic clk, rst_n;
  assign clk   = SC_ShiftCtrl_CLOCK_50;
  assign rst_n = SC_ShiftCtrl_RESET_InLow;

  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] vld_q;
  logic       armed_q;
  logic       start_evt;

  // armed_q only sets once the synchronised pin has genuinely been seen high,
  // so a button held through reset cannot masquerade as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= SC_ShiftCtrl_startButton_InLow;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      if (vld_q[1] && sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign start_evt = armed_q && prev_q && !sync2_q;

  state_e         state_q;
  logic [W-1:0]   data_q;
  logic           dir_q;
  logic           busy_q;
  logic           bounce_q;
  logic           load_go;
  logic           step;
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
  logic [7:0]     bcnt_q;
`endif

  assign load_go = (state_q == IDLE) && start_evt && (SC_ShiftCtrl_load_InBUS != '0);

  sc_shiftctrl_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (load_go),
    .enable_i(state_q != IDLE),
    .step_o  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      dir_q    <= DIR_LEFT;
      busy_q   <= 1'b0;
      bounce_q <= 1'b0;
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
      bcnt_q   <= 8'd0;
`endif
    end else begin
      bounce_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_go) begin
            data_q  <= SC_ShiftCtrl_load_InBUS;
            dir_q   <= DIR_LEFT;
            state_q <= RUN_LEFT;
            busy_q  <= 1'b1;
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
            bcnt_q  <= 8'd0;
`endif
          end
        end
        RUN_LEFT: begin
          if (start_evt) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (step) begin
            if (data_q[W-1]) begin
              dir_q    <= DIR_RIGHT;
              state_q  <= RUN_RIGHT;
              bounce_q <= 1'b1;
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
              bcnt_q   <= bcnt_q + 8'd1;
`endif
            end else begin
              data_q <= SC_ShiftCtrl_shifted_InBUS;
            end
          end
        end
        RUN_RIGHT: begin
          if (start_evt) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (step) begin
            if (data_q[0]) begin
              dir_q    <= DIR_LEFT;
              state_q  <= RUN_LEFT;
              bounce_q <= 1'b1;
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
              bcnt_q   <= bcnt_q + 8'd1;
`endif
            end else begin
              data_q <= SC_ShiftCtrl_shifted_InBUS;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SC_ShiftCtrl_data_OutBUS = data_q;
  assign SC_ShiftCtrl_dir_Out     = dir_q;
  assign SC_ShiftCtrl_busy_Out    = busy_q;
  assign SC_ShiftCtrl_bounce_Out  = bounce_q;
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
  assign SC_ShiftCtrl_bounces_OutBUS = bcnt_q;
`endif

endmodule

// File: tb/tb_sc_shift_pingpong_ctrl.sv
// Self-checking bench for sc_shift_pingpong_ctrl: table vectors, directed corners and a
// cycle-level reference model driven by random stimulus.
module tb_sc_shift_pingpong_ctrl;

  localparam int W    = 4;
  localparam int STEP = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         btn_n = 1'b1;
  logic [W-1:0] load  = '0;
  logic [W-1:0] rand_sh = '0;
  logic         use_rand = 1'b0;
  logic [W-1:0] shifted;
  logic [W-1:0] data;
  logic         dir, busy, bounce;
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
  logic [7:0]   bounces;
`endif

  always #5 clk = ~clk;

  // Downstream shifter, optionally replaced by arbitrary values.
  always_comb shifted = use_rand ? rand_sh : (dir ? (data >> 1) : (data << 1));

  sc_shift_pingpong_ctrl #(
    .RegSHIFTER_DATAWIDTH(W),
    .STEP_CYCLES(STEP)
  ) dut (
    .SC_ShiftCtrl_CLOCK_50         (clk),
    .SC_ShiftCtrl_RESET_InLow      (rst_n),
    .SC_ShiftCtrl_startButton_InLow(btn_n),
    .SC_ShiftCtrl_load_InBUS       (load),
    .SC_ShiftCtrl_shifted_InBUS    (shifted),
    .SC_ShiftCtrl_data_OutBUS      (data),
    .SC_ShiftCtrl_dir_Out          (dir),
    .SC_ShiftCtrl_busy_Out         (busy),
    .SC_ShiftCtrl_bounce_Out       (bounce)
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
    ,
    .SC_ShiftCtrl_bounces_OutBUS   (bounces)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: edge index n counts rising edges since reset release; pin_h[k] is the
  // button level seen at edge k. A start event lands on edge n when the pin was high at
  // edge n-3 and low at edge n-2. Steps fall every STEP edges after the load edge.
  int           n;
  bit           pin_h[$];
  bit           m_run, m_dir, m_bnc;
  logic [W-1:0] m_pat;
  int           m_t0;
  logic [7:0]   m_bcnt;

  task automatic model_reset();
    n = 0;
    pin_h.delete();
    pin_h.push_back(1'b0);
    m_run = 0; m_dir = 0; m_bnc = 0; m_pat = '0; m_t0 = 0; m_bcnt = 8'd0;
  endtask

  task automatic model_edge(input bit pin, input logic [W-1:0] ld,
                            input logic [W-1:0] rsh, input bit ur);
    bit ev;
    n++;
    pin_h.push_back(pin);
    ev = (n >= 4) && pin_h[n-3] && !pin_h[n-2];
    m_bnc = 0;
    if (!m_run) begin
      if (ev && ld != '0) begin
        m_run = 1; m_pat = ld; m_dir = 0; m_t0 = n; m_bcnt = 8'd0;
      end
    end else if (ev) begin
      m_run = 0;
    end else if ((n - m_t0) % STEP == 0) begin
      if (!m_dir && m_pat[W-1]) begin
        m_dir = 1; m_bnc = 1;
      end else if (m_dir && m_pat[0]) begin
        m_dir = 0; m_bnc = 1;
      end else begin
        m_pat = ur ? rsh : (m_dir ? (m_pat >> 1) : (m_pat << 1));
      end
      if (m_bnc) m_bcnt = m_bcnt + 8'd1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(btn_n, load, rand_sh, use_rand);
    #1;
    check("busy", busy, m_run);
    check("data", data, m_pat);
    check("dir", dir, m_dir);
    check("bounce", bounce, m_bnc);
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
    check("bounces", bounces, m_bcnt);
`endif
  endtask

  task automatic idle(input int k);
    repeat (k) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_data", data, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_bounce", bounce, 0);
`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
    check("rst_bounces", bounces, 0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_run(input logic [W-1:0] ld);
    load = ld;
    idle(4);
    btn_n = 1'b0;
    repeat (3) cyc();
    btn_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] load;
    logic         exp_busy;
    logic [W-1:0] exp_data;
  } vec_t;

  initial begin
    vec_t         tbl[5];
    int           log_q[$];
    int           exp_log[7];
    logic [W-1:0] last;
    int           rises, falls, busy_cnt, bc;
    logic         pb;

    tbl[0] = '{4'b0011, 1'b1, 4'b0011};
    tbl[1] = '{4'b0000, 1'b0, 4'b0000};
    tbl[2] = '{4'b1000, 1'b1, 4'b1000};
    tbl[3] = '{4'b1111, 1'b1, 4'b1111};
    tbl[4] = '{4'b0101, 1'b1, 4'b0101};
    exp_log = '{3, 6, 12, 60, 6, 3, 35};

    // Start events against a freshly reset block.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      start_run(tbl[i].load);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      check($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
      check($sformatf("tbl%0d_dir", i), dir, 0);
      idle(2);
    end

    // Full ping-pong trace from 0011; codes >= 32 are bounce pulses (32 + 16*dir + data).
    do_reset();
    use_rand = 1'b0;
    start_run(4'b0011);
    log_q.push_back(int'(data));
    last = data;
    for (int c = 0; c < 40 && log_q.size() < 7; c++) begin
      cyc();
      if (bounce) log_q.push_back(32 + 16 * int'(dir) + int'(data));
      else if (data != last) log_q.push_back(int'(data));
      last = data;
    end
    check("trace_len", log_q.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("trace%0d", i), (i < log_q.size()) ? log_q[i] : -1, exp_log[i]);

    // Stop press landing on the same edge as a step.
    do_reset();
    start_run(4'b0011);
    check("stopstep_running", busy, 1);
    for (int c = 0; c < 20 && n < m_t0 + 5; c++) cyc();
    btn_n = 1'b0;
    repeat (3) cyc();
    check("stopstep_busy", busy, 0);
    check("stopstep_data", data, 4'b0110);
    check("stopstep_bounce", bounce, 0);
    btn_n = 1'b1;
    cyc();
    check("stopstep_hold", data, 4'b0110);

    // Asynchronous reset mid-run while data = 0110, then restart from a clean prescaler.
    do_reset();
    start_run(4'b0011);
    for (int c = 0; c < 20 && n < m_t0 + 5; c++) cyc();
    check("midrun_data", data, 4'b0110);
    do_reset();
    start_run(4'b0011);
    idle(10);

    // Long press yields one start; release and press again stops.
    do_reset();
    load = 4'b0101;
    idle(4);
    btn_n = 1'b0;
    rises = 0; falls = 0; pb = busy;
    repeat (50) begin
      cyc();
      if (busy && !pb) rises++;
      if (!busy && pb) falls++;
      pb = busy;
    end
    check("held_starts", rises, 1);
    check("held_stops", falls, 0);
    btn_n = 1'b1;
    idle(4);
    check("held_still_busy", busy, 1);
    btn_n = 1'b0;
    repeat (3) cyc();
    btn_n = 1'b1;
    check("second_press_stop", busy, 0);

    // Button held low across reset must be released before it counts.
    btn_n = 1'b0;
    do_reset();
    busy_cnt = 0;
    repeat (20) begin
      cyc();
      if (busy) busy_cnt++;
    end
    check("held_through_reset", busy_cnt, 0);
    btn_n = 1'b1;
    start_run(4'b0101);
    check("after_release_start", busy, 1);

`ifdef SC_SHIFTCTRL_BOUNCECOUNT_EN
    do_reset();
    start_run(4'b1000);
    bc = 0;
    repeat (20 * STEP) begin
      cyc();
      if (bounce) bc++;
    end
    check("bcnt_vs_pulses", bounces, bc);
    check("bcnt_pulses", bc, 5);
    btn_n = 1'b0;
    repeat (3) cyc();
    btn_n = 1'b1;
    start_run(4'b1000);
    check("bcnt_reload_busy", busy, 1);
    check("bcnt_reload_clear", bounces, 0);
`else
    bc = 0;
`endif

    // Random presses, loads, shifter values and occasional resets against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      if ($urandom_range(0, 6) == 0) btn_n = ~btn_n;
      if ($urandom_range(0, 11) == 0) load = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      rand_sh  = W'($urandom);
      use_rand = ($urandom_range(0, 3) == 0);
      cyc();
    end
    use_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
